wb_traffic_master: RTL
======================

WB_TRAFFIC_MASTER -- requirements
Module: wb_traffic_master

Interface
REQ-001 Parameter aw, default 32: Wishbone address width.
REQ-002 Parameter dw, default 32: Wishbone data width, 32 only.
REQ-003 Parameter SEED, default 32'hA5A5_0000: data-pattern XOR seed.
REQ-004 Parameter TMO, default 1024: ack-timeout limit in cycles.
REQ-005 sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 RESETN  in  1  synchronous, active-low reset.
REQ-007 sdr_init_done  in  1  SDRAM controller init complete.
REQ-008 cmd_valid  in  1  command offered.
REQ-009 cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-010 cmd_we  in  1  1 = write burst, 0 = read-and-check burst.
REQ-011 cmd_addr  in  aw  byte start address, word aligned.
REQ-012 cmd_bl  in  8  burst length in beats; 0 means 256.
REQ-013 wb_cyc_i, wb_stb_i  out  1 each  Wishbone cycle/strobe to controller.
REQ-014 wb_we_i  out  1  Wishbone write enable.
REQ-015 wb_addr_i  out  aw  beat byte address.
REQ-016 wb_dat_i  out  dw  write data.
REQ-017 wb_sel_i  out  dw/8  byte enables.
REQ-018 wb_cti_i  out  3  cycle type.
REQ-019 wb_ack_o  in  1  beat acknowledge from controller.
REQ-020 wb_dat_o  in  dw  read data from controller.
REQ-021 done  out  1  one-cycle pulse, burst finished or aborted.
REQ-022 err_cnt  out  16  read-mismatch count.
REQ-023 timeout  out  1  sticky ack-timeout flag.

Function
REQ-024 FSM states SHALL be WAIT_INIT, IDLE, BURST, FIN.
REQ-025 WAIT_INIT -> IDLE on first edge sampling sdr_init_done=1; sdr_init_done ignored in all other states.
REQ-026 cmd_ready SHALL be 1 only in IDLE.
REQ-027 On accept: latch we/addr/bl, beat counter = 0, go BURST; wb_cyc_i=wb_stb_i=1 from next cycle.
REQ-028 In BURST wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i SHALL hold stable until the cycle wb_ack_o=1.
REQ-029 wb_sel_i SHALL be all ones in BURST, zero elsewhere.
REQ-030 Beat k: wb_addr_i = addr + 4k (mod 2^aw); expected/write data = (addr + 4k) XOR SEED.
REQ-031 Beat counter 9 bits; bl=0 gives 256 beats; counter advances one per acked beat.
REQ-032 wb_cti_i = 3'b010 for non-final beats, 3'b111 for final beat (including 1-beat bursts), 3'b000 outside BURST.
REQ-033 Read beat with ack: if wb_dat_o != expected, err_cnt increments, saturating at 16'hFFFF.
REQ-034 Ack on final beat -> FIN; cyc/stb/we drop the next cycle; no extra beat issued.
REQ-035 Ack-wait counter clears on each ack and on entry to BURST; reaching TMO cycles without ack sets timeout, aborts burst -> FIN.
REQ-036 FIN lasts exactly one cycle with done=1, then IDLE; command accepted earliest the cycle after FIN.
REQ-037 wb_ack_o outside BURST SHALL be ignored (no count, no compare).
REQ-038 Throughput: one beat per cycle when wb_ack_o held high.

Reset
REQ-039 RESETN=0 at an edge: state WAIT_INIT, all wb_* outputs 0, cmd_ready=0, done=0, err_cnt=0, timeout=0, counters 0.
REQ-040 Reset mid-burst SHALL abort immediately without done pulse; no partial state retained.

Verification
REQ-041 Init gating: cmd_valid=1 with sdr_init_done=0 for 50 cycles -> cmd_ready=0, wb_cyc_i=0; raise init_done -> accept 2 cycles later.
REQ-042 Write bl=4 addr 32'h100, slave acks every cycle -> addr 100/104/108/10C, data 32'hA5A5_0100..010C pattern, cti 010,010,010,111, done 1 cycle after last ack.
REQ-043 Read bl=2 addr 32'h200, slave returns expected then corrupted word -> err_cnt=1; corrupt both on 0xFFFF count -> stays 0xFFFF.
REQ-044 Wrap/length: bl=0 at addr 32'hFFFF_FFFC -> 256 beats, second beat addr 32'h0000_0000, counter terminates correctly.
REQ-045 Timeout: slave never acks -> after 1024 cycles timeout=1, done pulses, cyc low, next command still accepted.
REQ-046 Reset asserted on beat 3 of bl=8 -> next cycle all outputs at reset values, no done, FSM in WAIT_INIT.

Source files
------------

// File: rtl/wb_traffic_master.sv
// Wishbone burst traffic generator for SDRAM controller bring-up.
// Issues write or read-and-check bursts of address-derived data and tracks mismatches and ack timeouts.
module wb_traffic_master #(
    parameter int unsigned aw   = 32,
    parameter int unsigned dw   = 32,
    parameter logic [31:0] SEED = 32'hA5A5_0000,
    parameter int unsigned TMO  = 1024
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    input  logic            sdr_init_done,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [aw-1:0]   cmd_addr,
    input  logic [7:0]      cmd_bl,
    output logic            wb_cyc_i,
    output logic            wb_stb_i,
    output logic            wb_we_i,
    output logic [aw-1:0]   wb_addr_i,
    output logic [dw-1:0]   wb_dat_i,
    output logic [dw/8-1:0] wb_sel_i,
    output logic [2:0]      wb_cti_i,
    input  logic            wb_ack_o,
    input  logic [dw-1:0]   wb_dat_o,
    output logic            done,
    output logic [15:0]     err_cnt,
    output logic            timeout
);

    localparam int unsigned SW = dw / 8;
    localparam int unsigned TW = $clog2(TMO + 1);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {WAIT_INIT, IDLE, BURST, FIN} state_t;

    state_t          state_q, state_d;
    logic            rdy_q, rdy_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [aw-1:0]   addr_q, addr_d;
    logic [dw-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [2:0]      cti_q, cti_d;
    logic [7:0]      last_q, last_d;
    logic [8:0]      beat_q, beat_d;
    logic [TW-1:0]   wait_q, wait_d;
    logic [15:0]     err_q, err_d;
    logic            tmo_q, tmo_d;
    logic            done_q, done_d;
    logic [aw-1:0]   nxt_addr_c;

    // Beat data is the beat address scrambled with the seed; same pattern for writes and read checks.
    function automatic logic [dw-1:0] pattern(input logic [aw-1:0] a);
        return dw'(a) ^ dw'(SEED);
    endfunction

    assign nxt_addr_c = addr_q + aw'(4);

    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            state_q <= WAIT_INIT;
            rdy_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            cti_q   <= CTI_CLASSIC;
            last_q  <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            tmo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            cti_q   <= cti_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        cti_d   = cti_q;
        last_d  = last_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        unique case (state_q)
            WAIT_INIT: begin
                if (sdr_init_done) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end
            end
            IDLE: begin
                if (cmd_valid && rdy_q) begin
                    state_d = BURST;
                    rdy_d   = 1'b0;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    dat_d   = pattern(cmd_addr);
                    sel_d   = '1;
                    cti_d   = (cmd_bl == 8'd1) ? CTI_END : CTI_INCR;
                    last_d  = cmd_bl - 8'd1;
                    beat_d  = '0;
                    wait_d  = '0;
                end
            end
            BURST: begin
                if (wb_ack_o) begin
                    wait_d = '0;
                    if (!we_q && (wb_dat_o != dat_q) && (err_q != 16'hFFFF)) begin
                        err_d = err_q + 16'd1;
                    end
                    if (beat_q == {1'b0, last_q}) begin
                        state_d = FIN;
                    end else begin
                        beat_d = beat_q + 9'd1;
                        addr_d = nxt_addr_c;
                        dat_d  = pattern(nxt_addr_c);
                        cti_d  = ((beat_q + 9'd1) == {1'b0, last_q}) ? CTI_END : CTI_INCR;
                    end
                end else if (wait_q == TW'(TMO - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
                // Leaving the burst: bus returns to idle values the same edge.
                if (state_d == FIN) begin
                    done_d = 1'b1;
                    cyc_d  = 1'b0;
                    we_d   = 1'b0;
                    addr_d = '0;
                    dat_d  = '0;
                    sel_d  = '0;
                    cti_d  = CTI_CLASSIC;
                    beat_d = '0;
                    wait_d = '0;
                end
            end
            FIN: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
            end
            default: state_d = WAIT_INIT;
        endcase
    end

    assign cmd_ready = rdy_q;
    assign wb_cyc_i  = cyc_q;
    assign wb_stb_i  = cyc_q;
    assign wb_we_i   = we_q;
    assign wb_addr_i = addr_q;
    assign wb_dat_i  = dat_q;
    assign wb_sel_i  = sel_q;
    assign wb_cti_i  = cti_q;
    assign done      = done_q;
    assign err_cnt   = err_q;
    assign timeout   = tmo_q;

endmodule
